conv_tile_instgen: RTL and testbench

Parametrised next-generation convolution instruction generator. Sits between the CSR block and the stride decoder. It accepts one convolution command and walks the output plane in raster order. Output channels are split into tiles of up to OC_TILE channels. It emits one per-window instruction over a valid/ready handshake, supports independent horizontal and vertical strides, and adds abort and error reporting.

---
 rtl/conv_tile_instgen.sv | 232 +++++++++++++++++++++++
 tb/tb_conv_tile_instgen.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_tile_instgen.sv
// Convolution instruction generator: walks the output plane in raster order per output-channel tile
// and issues one window instruction per output pixel over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for a command, instgen_ready high
// INIT  | clear counters, load base addresses, validate config
// EXEC  | present instruction, advance on accept
// DONE  | one-cycle compute_done (and cfg_err on bad config)
module conv_tile_instgen #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FRAM_AW    = 14,
  parameter int KRAM_AW    = 14,
  parameter int OC_TILE    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] feature_baseaddr,
  input  logic [ADDR_WIDTH-1:0] kernel_baseaddr,
  input  logic [ADDR_WIDTH-1:0] output_baseaddr,
  input  logic [DATA_WIDTH-1:0] feature_width,
  input  logic [DATA_WIDTH-1:0] feature_chin,
  input  logic [DATA_WIDTH-1:0] feature_chout,
  input  logic [7:0]            kernel_sizeh,
  input  logic [7:0]            kernel_sizew,
  input  logic [7:0]            stride_h,
  input  logic [7:0]            stride_w,
  input  logic [DATA_WIDTH-1:0] output_width,
  input  logic [DATA_WIDTH-1:0] output_height,
  input  logic                  has_bias,
  input  logic                  has_relu,
  input  logic                  csrcmd_valid,
  output logic                  instgen_ready,
  input  logic                  abort,
  output logic [FRAM_AW-1:0]    inst_feature_addr,
  output logic [KRAM_AW-1:0]    inst_kernel_addr,
  output logic [FRAM_AW-1:0]    inst_wb_addr,
  output logic [DATA_WIDTH-1:0] inst_wb_ch_offset,
  output logic [DATA_WIDTH-1:0] inst_chin,
  output logic [DATA_WIDTH-1:0] inst_chout,
  output logic [7:0]            inst_kernel_sizeh,
  output logic [7:0]            inst_kernel_sizew,
  output logic [DATA_WIDTH-1:0] inst_feature_width,
  output logic                  inst_has_bias,
  output logic                  inst_has_relu,
  output logic                  inst_valid,
  input  logic                  decoder_ready,
  output logic                  compute_done,
  output logic                  cfg_err,
  output logic [DATA_WIDTH-1:0] inst_count
);

  typedef enum logic [1:0] {IDLE, INIT, EXEC, DONE} state_t;

  localparam logic [DATA_WIDTH-1:0] OC_TILE_D = DATA_WIDTH'(OC_TILE);

  state_t state;

  logic [DATA_WIDTH-1:0] w_r, chin_r, chout_r, ow_r, oh_r;
  logic [DATA_WIDTH-1:0] kwords_r, row_step_r, plane_r;
  logic [7:0]            kh_r, kw_r, sh_r, sw_r;
  logic                  bias_r, relu_r;
  logic [FRAM_AW-1:0]    fbase_r, obase_r;
  logic [KRAM_AW-1:0]    kbase_r;

  logic [DATA_WIDTH-1:0] ox, oy, oc_base, chout_tile, count_r;
  logic [FRAM_AW-1:0]    row_addr, feat_addr, orow_addr, wb_addr, wb_base;
  logic [KRAM_AW-1:0]    kaddr;
  logic                  valid_r, ready_r, done_r, err_r;

  logic                  accept, more_x, more_y, more_t, cfg_bad;
  logic [DATA_WIDTH-1:0] oc_next, oc_rem;
  logic [FRAM_AW-1:0]    row_next, orow_next, wb_tile_base;
  logic [KRAM_AW-1:0]    k_next;

  always_comb begin
    accept       = valid_r && decoder_ready;
    more_x       = ({1'b0, ox} + 1'b1) < {1'b0, ow_r};
    more_y       = ({1'b0, oy} + 1'b1) < {1'b0, oh_r};
    more_t       = ({1'b0, oc_base} + {1'b0, OC_TILE_D}) < {1'b0, chout_r};
    oc_next      = oc_base + OC_TILE_D;
    oc_rem       = chout_r - oc_next;
    row_next     = row_addr + FRAM_AW'(row_step_r);
    orow_next    = orow_addr + FRAM_AW'(ow_r);
    wb_tile_base = wb_base + FRAM_AW'(OC_TILE_D) * FRAM_AW'(plane_r);
    k_next       = kaddr + KRAM_AW'(OC_TILE_D) * KRAM_AW'(kwords_r);
    cfg_bad      = (ow_r == '0) || (oh_r == '0) || (chout_r == '0) ||
                   (sh_r == '0) || (sw_r == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      w_r        <= '0;  chin_r   <= '0;  chout_r <= '0;
      ow_r       <= '0;  oh_r     <= '0;
      kwords_r   <= '0;  row_step_r <= '0; plane_r <= '0;
      kh_r       <= '0;  kw_r     <= '0;  sh_r    <= '0;  sw_r <= '0;
      bias_r     <= 1'b0; relu_r  <= 1'b0;
      fbase_r    <= '0;  obase_r  <= '0;  kbase_r <= '0;
      ox         <= '0;  oy       <= '0;  oc_base <= '0;
      chout_tile <= '0;  count_r  <= '0;
      row_addr   <= '0;  feat_addr <= '0; orow_addr <= '0;
      wb_addr    <= '0;  wb_base  <= '0;  kaddr   <= '0;
      valid_r    <= 1'b0;
      ready_r    <= 1'b1;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (csrcmd_valid) begin
            w_r        <= feature_width;
            chin_r     <= feature_chin;
            chout_r    <= feature_chout;
            ow_r       <= output_width;
            oh_r       <= output_height;
            kh_r       <= kernel_sizeh;
            kw_r       <= kernel_sizew;
            sh_r       <= stride_h;
            sw_r       <= stride_w;
            bias_r     <= has_bias;
            relu_r     <= has_relu;
            fbase_r    <= feature_baseaddr[2 +: FRAM_AW];
            kbase_r    <= kernel_baseaddr[2 +: KRAM_AW];
            obase_r    <= output_baseaddr[2 +: FRAM_AW];
            kwords_r   <= DATA_WIDTH'(kernel_sizeh) * DATA_WIDTH'(kernel_sizew) * feature_chin;
            row_step_r <= DATA_WIDTH'(stride_h) * feature_width;
            plane_r    <= output_width * output_height;
            count_r    <= '0;
            ready_r    <= 1'b0;
            state      <= INIT;
          end
        end
        INIT: begin
          ox         <= '0;
          oy         <= '0;
          oc_base    <= '0;
          row_addr   <= fbase_r;
          feat_addr  <= fbase_r;
          kaddr      <= kbase_r;
          wb_base    <= obase_r;
          orow_addr  <= obase_r;
          wb_addr    <= obase_r;
          chout_tile <= (chout_r > OC_TILE_D) ? OC_TILE_D : chout_r;
          if (abort) begin
            ready_r <= 1'b1;
            state   <= IDLE;
          end else if (cfg_bad) begin
            done_r <= 1'b1;
            err_r  <= 1'b1;
            state  <= DONE;
          end else begin
            valid_r <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (accept) begin
            count_r <= count_r + 1'b1;
            if (more_x) begin
              ox        <= ox + 1'b1;
              feat_addr <= feat_addr + FRAM_AW'(sw_r);
              wb_addr   <= wb_addr + 1'b1;
            end else if (more_y) begin
              ox        <= '0;
              oy        <= oy + 1'b1;
              row_addr  <= row_next;
              feat_addr <= row_next;
              orow_addr <= orow_next;
              wb_addr   <= orow_next;
            end else if (more_t) begin
              ox         <= '0;
              oy         <= '0;
              oc_base    <= oc_next;
              chout_tile <= (oc_rem > OC_TILE_D) ? OC_TILE_D : oc_rem;
              kaddr      <= k_next;
              wb_base    <= wb_tile_base;
              orow_addr  <= wb_tile_base;
              wb_addr    <= wb_tile_base;
              row_addr   <= fbase_r;
              feat_addr  <= fbase_r;
            end else begin
              valid_r <= 1'b0;
              done_r  <= 1'b1;
              state   <= DONE;
            end
          end
          // abort overrides whatever the accept path decided, but the accept still counts
          if (abort) begin
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
            state   <= IDLE;
          end
        end
        DONE: begin
          ready_r <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          valid_r <= 1'b0;
          ready_r <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign instgen_ready      = ready_r;
  assign inst_valid         = valid_r;
  assign compute_done       = done_r;
  assign cfg_err            = err_r;
  assign inst_count         = count_r;
  assign inst_feature_addr  = feat_addr;
  assign inst_kernel_addr   = kaddr;
  assign inst_wb_addr       = wb_addr;
  assign inst_wb_ch_offset  = plane_r;
  assign inst_chin          = chin_r;
  assign inst_chout         = chout_tile;
  assign inst_kernel_sizeh  = kh_r;
  assign inst_kernel_sizew  = kw_r;
  assign inst_feature_width = w_r;
  assign inst_has_bias      = bias_r;
  assign inst_has_relu      = relu_r;

  // Address bits outside the word-address window and upper product bits are intentionally dropped.
  logic unused_ok;
  assign unused_ok = ^{feature_baseaddr, kernel_baseaddr, output_baseaddr, kwords_r, row_step_r};

endmodule

// File: tb/tb_conv_tile_instgen.sv
// Bench for conv_tile_instgen: table of commands plus random commands checked against a
// closed-form model of the instruction stream, and hand-written stall/abort/reset sequences.
module tb_conv_tile_instgen;

  localparam int FAW = 14;
  localparam int KAW = 14;
  localparam int OCT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] feature_baseaddr = '0, kernel_baseaddr = '0, output_baseaddr = '0;
  logic [31:0] feature_width = '0, feature_chin = '0, feature_chout = '0;
  logic [7:0]  kernel_sizeh = '0, kernel_sizew = '0, stride_h = '0, stride_w = '0;
  logic [31:0] output_width = '0, output_height = '0;
  logic        has_bias = 1'b0, has_relu = 1'b0, csrcmd_valid = 1'b0, abort = 1'b0;
  logic        decoder_ready = 1'b0;
  logic        instgen_ready, inst_valid, compute_done, cfg_err;
  logic [FAW-1:0] inst_feature_addr, inst_wb_addr;
  logic [KAW-1:0] inst_kernel_addr;
  logic [31:0] inst_wb_ch_offset, inst_chin, inst_chout, inst_feature_width, inst_count;
  logic [7:0]  inst_kernel_sizeh, inst_kernel_sizew;
  logic        inst_has_bias, inst_has_relu;

  conv_tile_instgen dut (
    .clk(clk), .rst(rst),
    .feature_baseaddr(feature_baseaddr), .kernel_baseaddr(kernel_baseaddr),
    .output_baseaddr(output_baseaddr), .feature_width(feature_width),
    .feature_chin(feature_chin), .feature_chout(feature_chout),
    .kernel_sizeh(kernel_sizeh), .kernel_sizew(kernel_sizew),
    .stride_h(stride_h), .stride_w(stride_w),
    .output_width(output_width), .output_height(output_height),
    .has_bias(has_bias), .has_relu(has_relu),
    .csrcmd_valid(csrcmd_valid), .instgen_ready(instgen_ready), .abort(abort),
    .inst_feature_addr(inst_feature_addr), .inst_kernel_addr(inst_kernel_addr),
    .inst_wb_addr(inst_wb_addr), .inst_wb_ch_offset(inst_wb_ch_offset),
    .inst_chin(inst_chin), .inst_chout(inst_chout),
    .inst_kernel_sizeh(inst_kernel_sizeh), .inst_kernel_sizew(inst_kernel_sizew),
    .inst_feature_width(inst_feature_width),
    .inst_has_bias(inst_has_bias), .inst_has_relu(inst_has_relu),
    .inst_valid(inst_valid), .decoder_ready(decoder_ready),
    .compute_done(compute_done), .cfg_err(cfg_err), .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          w, chin, chout, kh, kw, sh, sw, ow, oh;
    logic [31:0] fb, kb, ob;
    bit          bias, relu;
    int          n_exp;   // -1: take the count from the model
  } vec_t;

  typedef struct {
    logic [FAW-1:0] feat;
    logic [KAW-1:0] kaddr;
    logic [FAW-1:0] wb;
    logic [31:0]    chout;
  } exp_t;

  exp_t model_q[$];
  exp_t log_q[$];
  vec_t tbl[9];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit is_bad(input vec_t v);
    return (v.ow == 0) || (v.oh == 0) || (v.chout == 0) || (v.sh == 0) || (v.sw == 0);
  endfunction

  // Closed-form stream: tile outer, then row, then column.
  function automatic void build_model(input vec_t v);
    longint fb, kb, ob, kwords, plane, rem;
    exp_t e;
    model_q.delete();
    if (is_bad(v)) return;
    fb = longint'(v.fb[15:2]);
    kb = longint'(v.kb[15:2]);
    ob = longint'(v.ob[15:2]);
    kwords = longint'(v.kh) * v.kw * v.chin;
    plane  = longint'(v.ow) * v.oh;
    for (int t = 0; t * OCT < v.chout; t++)
      for (int y = 0; y < v.oh; y++)
        for (int x = 0; x < v.ow; x++) begin
          rem     = longint'(v.chout) - longint'(t) * OCT;
          e.feat  = FAW'(fb + longint'(y) * v.sh * v.w + longint'(x) * v.sw);
          e.kaddr = KAW'(kb + longint'(t) * OCT * kwords);
          e.wb    = FAW'(ob + longint'(t) * OCT * plane + longint'(y) * v.ow + x);
          e.chout = 32'((rem > OCT) ? OCT : rem);
          model_q.push_back(e);
        end
  endfunction

  task automatic drive_cfg(input vec_t v);
    feature_baseaddr = v.fb;  kernel_baseaddr = v.kb;  output_baseaddr = v.ob;
    feature_width = 32'(v.w); feature_chin = 32'(v.chin); feature_chout = 32'(v.chout);
    kernel_sizeh = 8'(v.kh);  kernel_sizew = 8'(v.kw);
    stride_h = 8'(v.sh);      stride_w = 8'(v.sw);
    output_width = 32'(v.ow); output_height = 32'(v.oh);
    has_bias = v.bias;        has_relu = v.relu;
  endtask

  task automatic scramble_cfg();
    feature_baseaddr = $urandom; kernel_baseaddr = $urandom; output_baseaddr = $urandom;
    feature_width = $urandom; feature_chin = $urandom; feature_chout = $urandom;
    kernel_sizeh = 8'($urandom); kernel_sizew = 8'($urandom);
    stride_h = 8'($urandom); stride_w = 8'($urandom);
    output_width = $urandom; output_height = $urandom;
    has_bias = 1'($urandom); has_relu = 1'($urandom);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, instgen_ready, 1'b1);
    check({tag, "_ctl"}, {inst_valid, compute_done, cfg_err, inst_count, inst_feature_addr,
                          inst_kernel_addr, inst_wb_addr, inst_chout}, '0);
    check({tag, "_cfg"}, {inst_wb_ch_offset, inst_chin, inst_feature_width, inst_kernel_sizeh,
                          inst_kernel_sizew, inst_has_bias, inst_has_relu}, '0);
  endtask

  task automatic run_cmd(input vec_t v, input int ready_pct, input int stall_at);
    exp_t e, a;
    int   n_acc, cyc, budget, stall, total;
    bit   seen, fin, rdy, bad;
    n_acc = 0; cyc = 0; stall = 0; seen = 0; fin = 0;
    bad = is_bad(v);
    build_model(v);
    total  = model_q.size();
    budget = 12 * total + 40;
    log_q.delete();
    check("idle_ready", instgen_ready, 1'b1);
    drive_cfg(v);
    csrcmd_valid = 1'b1;
    decoder_ready = 1'b0;
    @(posedge clk); #1;
    csrcmd_valid = 1'b0;
    scramble_cfg();
    while (!fin && cyc < budget) begin
      cyc++;
      check("inst_count_run", inst_count, 32'(n_acc));
      if (compute_done) begin
        check("done_err", cfg_err, bad);
        check("done_valid", inst_valid, 1'b0);
        check("done_left", model_q.size(), 0);
        if (bad) check("err_latency", cyc, 2);
        fin = 1'b1;
        decoder_ready = 1'b0;
      end else if (inst_valid) begin
        a.feat = inst_feature_addr; a.kaddr = inst_kernel_addr;
        a.wb = inst_wb_addr;        a.chout = inst_chout;
        if (!seen) begin
          check("first_latency", cyc, 2);
          seen = 1'b1;
        end
        if (model_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL extra_inst: actual feat 0x%0h wb 0x%0h required none", a.feat, a.wb);
          fin = 1'b1;
        end else begin
          e = model_q[0];
          check("payload", {a.feat, a.kaddr, a.wb, a.chout}, {e.feat, e.kaddr, e.wb, e.chout});
          check("static", {inst_chin, inst_kernel_sizeh, inst_kernel_sizew, inst_feature_width,
                           inst_wb_ch_offset, inst_has_bias, inst_has_relu},
                          {32'(v.chin), 8'(v.kh), 8'(v.kw), 32'(v.w), 32'(v.ow * v.oh),
                           v.bias, v.relu});
          rdy = ($urandom_range(0, 99) < ready_pct);
          if (stall_at == n_acc && stall < 5) begin
            rdy = 1'b0;
            stall++;
          end
          decoder_ready = rdy;
          if (rdy) begin
            log_q.push_back(a);
            model_q.delete(0);
            n_acc++;
          end
        end
      end else begin
        decoder_ready = 1'($urandom_range(0, 1));
      end
      if (!fin) begin
        @(posedge clk); #1;
      end
    end
    decoder_ready = 1'b0;
    if (!fin) begin
      n_vec++; n_err++;
      $display("FAIL timeout: no compute_done within %0d cycles, got %0d of %0d", budget, n_acc, total);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end else begin
      @(posedge clk); #1;
      check("done_one_cycle", compute_done, 1'b0);
      check("back_idle", instgen_ready, 1'b1);
      check("inst_count_final", inst_count, 32'((v.n_exp >= 0) ? v.n_exp : total));
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   n;
    bit   hit, saw;

    //          w  chin chout kh kw sh sw ow oh  fb            kb            ob            b  r  n
    tbl[0] = '{5, 4, 10, 3, 3, 1, 1, 3, 3, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 18};
    tbl[1] = '{7, 2, 4,  3, 3, 2, 2, 3, 3, 32'h0,         32'h0,         32'h0,         1'b1, 1'b0, 9};
    tbl[2] = '{6, 1, 3,  1, 1, 2, 1, 4, 2, 32'h0,         32'h0,         32'h0,         1'b0, 1'b1, 8};
    tbl[3] = '{5, 4, 10, 3, 3, 1, 1, 0, 3, 32'h100,       32'h200,       32'h300,       1'b0, 1'b0, 0};
    tbl[4] = '{5, 4, 0,  3, 3, 1, 1, 3, 3, 32'h0,         32'h0,         32'h0,         1'b1, 1'b1, 0};
    tbl[5] = '{5, 4, 10, 3, 3, 1, 0, 3, 3, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 0};
    tbl[6] = '{5, 4, 10, 3, 3, 0, 1, 3, 3, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 0};
    tbl[7] = '{5, 1, 17, 1, 1, 1, 1, 2, 2, 32'h0000_FFF8, 32'hFFFF_FFFC, 32'h1234_5678, 1'b1, 1'b1, 12};
    tbl[8] = '{3, 2, 16, 1, 1, 1, 1, 1, 1, 32'h40,        32'h80,        32'hC0,        1'b0, 1'b0, 2};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset("reset");

    for (int i = 0; i < 9; i++) begin
      run_cmd(tbl[i], (i == 0) ? 100 : 70, -1);
      if (i == 0) begin
        check("tp1_first", {log_q[0].feat, log_q[0].kaddr, log_q[0].wb, log_q[0].chout},
                           {14'd0, 14'd0, 14'd0, 32'd8});
        check("tp1_ninth", {log_q[8].feat, log_q[8].kaddr, log_q[8].wb, log_q[8].chout},
                           {14'd12, 14'd0, 14'd8, 32'd8});
        check("tp1_tenth", {log_q[9].feat, log_q[9].kaddr, log_q[9].wb, log_q[9].chout},
                           {14'd0, 14'd288, 14'd72, 32'd2});
      end
      if (i == 1) check("tp2_oy1_ox2", {log_q[5].feat, log_q[5].wb}, {14'd18, 14'd5});
      if (i == 2) begin
        check("tp3_row1", log_q[4].feat, 14'd12);
        check("tp3_col1", log_q[1].feat, 14'd1);
      end
    end

    // five-cycle decoder stall in the middle of the stream
    run_cmd(tbl[0], 100, 5);

    // abort at the fourth instruction, without and with a same-edge accept
    for (int variant = 0; variant < 2; variant++) begin
      drive_cfg(tbl[0]);
      csrcmd_valid = 1'b1;
      @(posedge clk); #1;
      csrcmd_valid = 1'b0;
      n = 0; hit = 1'b0;
      for (int c = 0; c < 40 && !hit; c++) begin
        if (inst_valid && n == 3) begin
          abort = 1'b1;
          decoder_ready = 1'(variant);
          hit = 1'b1;
        end else begin
          decoder_ready = 1'b1;
          if (inst_valid) n++;
        end
        @(posedge clk); #1;
      end
      abort = 1'b0;
      decoder_ready = 1'b0;
      check("abort_reached", hit, 1'b1);
      check("abort_state", {inst_valid, instgen_ready, compute_done}, 3'b010);
      check("abort_count", inst_count, 32'(3 + variant));
      saw = 1'b0;
      repeat (3) begin
        @(posedge clk); #1;
        saw = saw | compute_done | inst_valid;
      end
      check("abort_quiet", saw, 1'b0);
      run_cmd(tbl[0], 100, -1);
    end

    // reset in the middle of EXEC
    drive_cfg(tbl[1]);
    csrcmd_valid = 1'b1;
    @(posedge clk); #1;
    csrcmd_valid = 1'b0;
    decoder_ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("pre_rst_busy", inst_valid, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    decoder_ready = 1'b0;
    check_reset("rst_mid");
    run_cmd(tbl[1], 80, -1);

    for (int r = 0; r < 40; r++) begin
      v.w     = $urandom_range(1, 12);
      v.chin  = $urandom_range(1, 5);
      v.chout = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 20);
      v.kh    = $urandom_range(1, 3);
      v.kw    = $urandom_range(1, 3);
      v.sh    = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 3);
      v.sw    = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 3);
      v.ow    = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 5);
      v.oh    = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 4);
      v.fb    = $urandom;
      v.kb    = $urandom;
      v.ob    = $urandom;
      v.bias  = 1'($urandom);
      v.relu  = 1'($urandom);
      v.n_exp = -1;
      run_cmd(v, $urandom_range(30, 100), $urandom_range(0, 8));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
